// File: rtl/shift_issue_wb_if.sv
// Request / shifter / result signal bundle for shift_issue_wb.
// The slave modport is the issue block; the master modport is its environment.
interface shift_issue_wb_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_data;
   logic [4:0]  req_amt;
   logic        req_rot;
   logic [3:0]  req_tag;
   logic [31:0] sh_in;
   logic        sh_rotate;
   logic [4:0]  sh_select;
   logic [31:0] sh_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [3:0]  res_tag;
   logic        busy;

   modport slave (
      input  req_valid, req_data, req_amt, req_rot, req_tag, sh_out, res_ready,
      output req_ready, sh_in, sh_rotate, sh_select, res_valid, res_data, res_tag, busy
   );

   modport master (
      output req_valid, req_data, req_amt, req_rot, req_tag, sh_out, res_ready,
      input  req_ready, sh_in, sh_rotate, sh_select, res_valid, res_data, res_tag, busy
   );
endinterface

// File: rtl/shift_issue_wb.sv
// Issues shift/rotate requests to an external fixed-latency shifter and collects
// the results in a credit-protected show-ahead FIFO, returned in acceptance order.
module shift_issue_wb_chk #(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input logic          clk,
   input logic          rst_n,
   input logic          push,
   input logic [CW-1:0] count,
   input logic [CW-1:0] credits
);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == CW'(DEPTH))));
   a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
      credits <= CW'(DEPTH));
endmodule

module shift_issue_wb #(
   parameter int DEPTH = 8,
   parameter int LAT   = 5
) (
   input logic            clk,
   input logic            rst_n,
   shift_issue_wb_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [PW-1:0] PONE_C  = PW'(1);

   logic [LAT-1:0] valid_q, valid_d;
   logic [3:0]     tag_q [LAT];
   logic [3:0]     tag_d [LAT];
   logic [31:0]    mem_q [DEPTH];
   logic [31:0]    mem_d [DEPTH];
   logic [3:0]     mtag_q [DEPTH];
   logic [3:0]     mtag_d [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d, credits_q, credits_d;
   logic           ready_s, accept_s, pop_s, push_s, res_valid_s;

   assign ready_s     = (credits_q != {CW{1'b0}});
   assign res_valid_s = (count_q != {CW{1'b0}});
   assign accept_s    = bus.req_valid & ready_s;
   assign pop_s       = res_valid_s & bus.res_ready;
   assign push_s      = valid_q[LAT-1];

   // Idle cycles send an all-zero bubble to the shifter.
   always_comb begin
      if (accept_s) begin
         bus.sh_in     = bus.req_data;
         bus.sh_rotate = bus.req_rot;
         bus.sh_select = bus.req_amt;
      end else begin
         bus.sh_in     = 32'h0000_0000;
         bus.sh_rotate = 1'b0;
         bus.sh_select = 5'd0;
      end
   end

   always_comb begin
      valid_d[0] = accept_s;
      tag_d[0]   = bus.req_tag;
      for (int i = 1; i < LAT; i++) begin
         valid_d[i] = valid_q[i-1];
         tag_d[i]   = tag_q[i-1];
      end
   end

   // FIFO write, read and occupancy; the shifter output is captured when its request reaches the last stage.
   always_comb begin
      mem_d    = mem_q;
      mtag_d   = mtag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         mem_d[wr_ptr_q]  = bus.sh_out;
         mtag_d[wr_ptr_q] = tag_q[LAT-1];
         wr_ptr_d         = wr_ptr_q + PONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PONE_C;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   // A credit leaves on accept and returns on pop, so in-flight plus stored never exceeds DEPTH.
   always_comb begin
      case ({accept_s, pop_s})
         2'b10:   credits_d = credits_q - ONE_C;
         2'b01:   credits_d = credits_q + ONE_C;
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= {LAT{1'b0}};
         wr_ptr_q  <= {PW{1'b0}};
         rd_ptr_q  <= {PW{1'b0}};
         count_q   <= {CW{1'b0}};
         credits_q <= DEPTH_C;
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= 4'd0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i]  <= 32'h0000_0000;
            mtag_q[i] <= 4'd0;
         end
      end else begin
         valid_q   <= valid_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         credits_q <= credits_d;
         tag_q     <= tag_d;
         mem_q     <= mem_d;
         mtag_q    <= mtag_d;
      end
   end

   always_comb begin
      bus.req_ready = ready_s;
      bus.res_valid = res_valid_s;
      bus.busy      = (|valid_q) | res_valid_s;
      if (res_valid_s) begin
         bus.res_data = mem_q[rd_ptr_q];
         bus.res_tag  = mtag_q[rd_ptr_q];
      end else begin
         bus.res_data = 32'h0000_0000;
         bus.res_tag  = 4'd0;
      end
   end

   shift_issue_wb_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .count   (count_q),
      .credits (credits_q)
   );
endmodule

// File: tb/tb_shift_issue_wb.sv
// Bench for shift_issue_wb: an external shifter model, a transaction-level
// reference (queue of accepted results with due cycles) checked every cycle, and directed scenarios.
module tb_shift_issue_wb;
   localparam int DEPTH = 8;
   localparam int LAT   = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   shift_issue_wb_if bus ();

   shift_issue_wb #(.DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] shref(input logic [31:0] d, input logic [4:0] a, input logic r);
      logic [63:0] dd;
      dd = {d, d} >> a;
      if (r) return dd[31:0];
      return d >> a;
   endfunction

   // External shifter: deliberately unreset, LAT registered stages.
   logic [31:0] shp [LAT];
   always @(posedge clk) begin
      shp[0] <= shref(bus.sh_in, bus.sh_select, bus.sh_rotate);
      for (int i = 1; i < LAT; i++) shp[i] <= shp[i-1];
   end
   assign bus.sh_out = shp[LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic [3:0]  t;
      int          due;
   } ent_t;
   ent_t       mq[$];
   logic [3:0] pop_log[$];

   // Reference: compare at negedge, then predict the coming edge from the now-stable inputs.
   initial begin
      logic ev, er, ea;
      forever begin
         @(negedge clk);
         if (!rst_n) mq.delete();
         ev = (mq.size() != 0) && (mq[0].due <= cyc);
         er = (mq.size() < DEPTH);
         ea = bus.req_valid && er;
         chk("res_valid", bus.res_valid, ev);
         chk("req_ready", bus.req_ready, er);
         chk("busy", bus.busy, mq.size() != 0);
         chk("sh_in", bus.sh_in, ea ? bus.req_data : 32'h0);
         chk("sh_rotate", bus.sh_rotate, ea ? bus.req_rot : 1'b0);
         chk("sh_select", bus.sh_select, ea ? bus.req_amt : 5'd0);
         if (ev) begin
            chk("res_data", bus.res_data, mq[0].d);
            chk("res_tag", bus.res_tag, mq[0].t);
         end
         if (rst_n) begin
            if (ev && bus.res_ready) begin
               pop_log.push_back(bus.res_tag);
               void'(mq.pop_front());
            end
            if (ea) mq.push_back('{shref(bus.req_data, bus.req_amt, bus.req_rot), bus.req_tag, cyc + LAT + 1});
            cyc++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [31:0] d, input logic [4:0] a,
                          input logic r, input logic [3:0] t);
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_amt   = a;
      bus.req_rot   = r;
      bus.req_tag   = t;
   endtask

   // One isolated request; latency counted from the cycle it is presented.
   task automatic single(input logic [31:0] d, input logic [4:0] a, input logic r,
                         input logic [3:0] t, input logic [31:0] expd);
      int lat;
      set_req(1'b1, d, a, r, t);
      bus.res_ready = 1'b1;
      step();
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      lat = 1;
      while (!bus.res_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("lit_latency", lat, 6);
      chk("lit_data", bus.res_data, expd);
      chk("lit_tag", bus.res_tag, t);
      step();
   endtask

   typedef struct {
      logic [31:0] d;
      logic [4:0]  a;
      logic        r;
      logic [31:0] e;
   } vec_t;
   vec_t vecs[8] = '{
      '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001},
      '{32'h0000_0001, 5'd1,  1'b1, 32'h8000_0000},
      '{32'h0000_F00F, 5'd4,  1'b1, 32'hF000_0F00},
      '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678},
      '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678},
      '{32'hDEAD_BEEF, 5'd16, 1'b0, 32'h0000_DEAD},
      '{32'hDEAD_BEEF, 5'd8,  1'b1, 32'hEFDE_ADBE},
      '{32'h8000_0001, 5'd31, 1'b1, 32'h0000_0003}
   };

   initial begin
      int acc;
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      bus.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_data", bus.res_data, 32'h0);
      chk("rst_res_tag", bus.res_tag, 4'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_sh_in", bus.sh_in, 32'h0);
      rst_n = 1'b1;
      // Accept is possible from the very first edge after release.
      single(vecs[0].d, vecs[0].a, vecs[0].r, 4'd3, vecs[0].e);
      for (int i = 1; i < 8; i++) single(vecs[i].d, vecs[i].a, vecs[i].r, 4'(i + 4), vecs[i].e);

      // Ten back-to-back requests against a stalled output: only DEPTH fit.
      bus.res_ready = 1'b0;
      acc = 0;
      pop_log.delete();
      for (int i = 0; i < 10; i++) begin
         set_req(1'b1, 32'hC0DE_0000 | 32'(i * 32'h111), 5'(i), 1'(i % 2), 4'(i));
         @(negedge clk);
         chk("b2b_ready", bus.req_ready, i < 8);
         if (bus.req_ready) acc++;
         step();
      end
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      chk("b2b_accepted", acc, 8);
      repeat (LAT + 2) step();
      bus.res_ready = 1'b1;
      for (int k = 0; k < 40 && pop_log.size() < 8; k++) step();
      chk("drain_count", pop_log.size(), 8);
      for (int k = 0; k < 8 && k < pop_log.size(); k++) chk("drain_tag", pop_log[k], 4'(k));

      // Full FIFO, no credits: a single pop frees exactly one credit.
      bus.res_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_req(1'b1, 32'hA5A5_0000 | 32'(i), 5'd2, 1'b0, 4'(i));
         step();
      end
      chk("full_ready", bus.req_ready, 1'b0);
      chk("full_valid", bus.res_valid, 1'b1);
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("pop_ready_before", bus.req_ready, 1'b0);
      step();
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk("pop_ready_after", bus.req_ready, 1'b1);
      step();
      @(negedge clk);
      chk("reaccept_ready", bus.req_ready, 1'b0);
      step();
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      bus.res_ready = 1'b1;
      repeat (20) step();

      // Sustained throughput with the output always ready.
      for (int i = 0; i < 24; i++) begin
         set_req(1'b1, 32'(i) * 32'h0102_0304 ^ 32'h5A5A_5A5A, 5'(i * 7), 1'(i % 3 == 0), 4'(i));
         @(negedge clk);
         chk("stream_ready", bus.req_ready, 1'b1);
         step();
      end
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      repeat (12) step();

      // Reset with two results stored and three still in the shifter.
      bus.res_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_req(1'b1, 32'hBAD0_0000 | 32'(i), 5'd1, 1'b0, 4'(i + 10));
         step();
      end
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      repeat (LAT + 2) step();
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 32'hBAD1_0000 | 32'(i), 5'd3, 1'b1, 4'(i + 12));
         step();
      end
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      chk("pre_rst_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_res_valid", bus.res_valid, 1'b0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_ready", bus.req_ready, 1'b1);
      repeat (2) step();
      rst_n = 1'b1;
      set_req(1'b1, 32'h0F0F_0F0F, 5'd4, 1'b1, 4'd9);
      bus.res_ready = 1'b1;
      step();
      set_req(1'b0, 32'h0, 5'd0, 1'b0, 4'd0);
      repeat (15) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
